// File: rtl/sid_voice_vca_pkg.sv
// Shared SID constants and the VCA state encoding.
// The widths are the defaults used by the voice datapath (oscillator,
// envelope, VCA and mixer). The VCA state type is exported so that
// checkers can decode the debug state output.
package sid_voice_vca_pkg;

  localparam int SID_WAVE_W   = 12;  // oscillator waveform width (unsigned)
  localparam int SID_ENV_W    = 8;   // envelope level width (unsigned)
  localparam int SID_SAMPLE_W = 20;  // signed voice sample width

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } vca_state_e;

endpackage

// File: rtl/sid_voice_vca_mul_serial.sv
// Shift-add serial multiplier: signed multiplicand a_i times unsigned
// multiplier b_i. The product is accumulated over B_W clock steps.
//
// Ports
//   clk_i, rst_i : clock, asynchronous active-high reset
//   start_i      : load operands when idle (ignored while a multiply runs)
//   a_i          : signed multiplicand, sign-extended to P_W bits
//   b_i          : unsigned multiplier
//   done_o       : high during the cycle whose closing edge applies the last step
//   p_o          : accumulator; holds the final product once done_o has been seen
//
// Handshake: start_i is sampled on a clock edge while the core is idle. The
// core then takes B_W steps. done_o is high in the cycle before the final
// edge, so the caller can change state on the same edge as the last step.
module sid_voice_vca_mul_serial #(
  parameter int A_W = 12,
  parameter int B_W = 8,
  parameter int P_W = 20
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic signed [A_W-1:0] a_i,
  input  logic [B_W-1:0]        b_i,
  output logic                  done_o,
  output logic [P_W-1:0]        p_o
);

  localparam int CNT_W = (B_W > 1) ? $clog2(B_W) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [P_W-1:0]   acc_q;
  logic [P_W-1:0]   mcand_q;
  logic [B_W-1:0]   mplier_q;
  logic             run_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      run_q    <= 1'b0;
    end else if (run_q) begin
      // Modulo-2^P_W add is exact because the true product fits in P_W bits.
      if (mplier_q[0]) acc_q <= acc_q + mcand_q;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - 1'b1;
      if (cnt_q == '0) run_q <= 1'b0;
    end else if (start_i) begin
      cnt_q    <= CNT_W'(B_W - 1);
      acc_q    <= '0;
      mcand_q  <= {{(P_W-A_W){a_i[A_W-1]}}, a_i};
      mplier_q <= b_i;
      run_q    <= 1'b1;
    end
  end

  assign done_o = run_q && (cnt_q == '0);
  assign p_o    = acc_q;

endmodule

// File: rtl/sid_voice_vca.sv
// Per-voice amplitude stage. Each CLKen tick it multiplies the offset-binary
// waveform by the envelope level and produces a full-precision signed sample.
//
// Ports
//   CLK, RST  : master clock, asynchronous active-high reset
//   CLKen     : sample strobe, one CLK wide
//   WAVE      : oscillator waveform, unsigned, midpoint 2**(WAVE_W-1)
//   ENV       : envelope level, unsigned
//   MUTE      : forces the captured sample to zero
//   OUT       : signed voice sample, held between VALID pulses
//   VALID     : one-CLK pulse when OUT updates (ENV_W+1 edges after CLKen)
//   BUSY      : multiply in progress (from the capture edge to the output edge)
//   OVERRUN   : sticky, set when CLKen arrives while BUSY; cleared by RST
//   STATE_DBG : current FSM state (vca_state_e encoding)
//
// Handshake: CLKen is a strobe with no back-pressure. It is accepted only in
// IDLE. A strobe seen in MUL or DONE is dropped and flagged in OVERRUN.
// VALID qualifies OUT for exactly one cycle.
module sid_voice_vca
  import sid_voice_vca_pkg::*;
#(
  parameter int WAVE_W = SID_WAVE_W,
  parameter int ENV_W  = SID_ENV_W,
  parameter int OUT_W  = SID_SAMPLE_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CLKen,
  input  logic [WAVE_W-1:0] WAVE,
  input  logic [ENV_W-1:0]  ENV,
  input  logic              MUTE,
  output logic [OUT_W-1:0]  OUT,
  output logic              VALID,
  output logic              BUSY,
  output logic              OVERRUN,
  output logic [1:0]        STATE_DBG
);

  vca_state_e         state_q;
  logic [OUT_W-1:0]   out_q;
  logic               valid_q;
  logic               busy_q;
  logic               overrun_q;
  logic               mute_q;

  logic               mul_start;
  logic               mul_done;
  logic [OUT_W-1:0]   mul_p;
  logic signed [WAVE_W-1:0] wave_s;

  // Inverting the MSB turns offset binary into two's complement (WAVE - midpoint).
  assign wave_s    = {~WAVE[WAVE_W-1], WAVE[WAVE_W-2:0]};
  assign mul_start = CLKen && (state_q == ST_IDLE);

  sid_voice_vca_mul_serial #(
    .A_W (WAVE_W),
    .B_W (ENV_W),
    .P_W (OUT_W)
  ) u_mul (
    .clk_i   (CLK),
    .rst_i   (RST),
    .start_i (mul_start),
    .a_i     (wave_s),
    .b_i     (ENV),
    .done_o  (mul_done),
    .p_o     (mul_p)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      out_q     <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      mute_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      // A strobe outside IDLE (including the DONE cycle) is dropped.
      if (CLKen && (state_q != ST_IDLE)) overrun_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (CLKen) begin
            mute_q  <= MUTE;
            busy_q  <= 1'b1;
            state_q <= ST_MUL;
          end
        end
        ST_MUL: begin
          if (mul_done) state_q <= ST_DONE;
        end
        ST_DONE: begin
          out_q   <= mute_q ? '0 : mul_p;
          valid_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign OUT       = out_q;
  assign VALID     = valid_q;
  assign BUSY      = busy_q;
  assign OVERRUN   = overrun_q;
  assign STATE_DBG = state_q;

endmodule

// File: tb/tb_sid_voice_vca.sv
// Bench for sid_voice_vca: a behavioural model (a queue of pending samples with
// due edges) checked against the DUT on every cycle, plus directed literal cases.
module tb_sid_voice_vca;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clken = 1'b0;
  logic [11:0] wave = '0;
  logic [7:0]  env = '0;
  logic        mute = 1'b0;
  logic [19:0] out;
  logic        valid, busy, overrun;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  sid_voice_vca dut (
    .CLK       (clk),
    .RST       (rst),
    .CLKen     (clken),
    .WAVE      (wave),
    .ENV       (env),
    .MUTE      (mute),
    .OUT       (out),
    .VALID     (valid),
    .BUSY      (busy),
    .OVERRUN   (overrun),
    .STATE_DBG (dbg_state)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A sample accepted at edge e appears on OUT at edge e+9. Strobes while a
  // sample is pending (through its output edge) are dropped and set overrun.
  logic [19:0] exp_q[$];
  int          due_q[$];
  int          edge_n = 0;
  logic [19:0] m_out = '0;
  logic        m_valid = 1'b0;
  logic        m_ovr = 1'b0;

  function automatic logic [19:0] model_product(input logic [11:0] w, input logic [7:0] e,
                                                input logic m);
    int p;
    p = m ? 0 : (int'(w) - 2048) * int'(e);
    return 20'(p);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      due_q.delete();
      m_out   = '0;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end else begin
      bit was_pending;
      edge_n++;
      m_valid = 1'b0;
      was_pending = (due_q.size() != 0);
      if (clken) begin
        if (was_pending) m_ovr = 1'b1;
        else begin
          exp_q.push_back(model_product(wave, env, mute));
          due_q.push_back(edge_n + 9);
        end
      end
      if (was_pending && due_q[0] == edge_n) begin
        m_valid = 1'b1;
        m_out   = exp_q.pop_front();
        void'(due_q.pop_front());
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_valid", 32'(valid), 32'(m_valid));
      chk("cyc_busy", 32'(busy), 32'(due_q.size() != 0));
      chk("cyc_overrun", 32'(overrun), 32'(m_ovr));
      chk("cyc_out", 32'(out), 32'(m_out));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [11:0] w, input logic [7:0] e, input logic m, input int gap);
    @(negedge clk);
    clken = 1'b1; wave = w; env = e; mute = m;
    @(negedge clk);
    clken = 1'b0;
    wave = 12'($urandom); env = 8'($urandom); mute = 1'($urandom);
    repeat (gap - 2) @(negedge clk);
  endtask

  // Strobe once, wait for VALID, pin latency and value to hand-computed literals.
  task automatic directed(input string nm, input logic [11:0] w, input logic [7:0] e,
                          input logic m, input logic [19:0] lit, input bit toggle);
    int k;
    bit seen;
    @(negedge clk);
    clken = 1'b1; wave = w; env = e; mute = m;
    @(negedge clk);
    clken = 1'b0;
    k = 1;
    seen = 1'b0;
    while (k <= 20 && !seen) begin
      if (valid) seen = 1'b1;
      else begin
        if (toggle) begin
          wave = 12'($urandom); env = 8'($urandom); mute = ~mute;
        end
        @(negedge clk);
        k++;
      end
    end
    if (seen) begin
      chk({nm, "_latency"}, 32'(k - 1), 32'd9);
      chk({nm, "_out"}, 32'(out), 32'(lit));
      chk({nm, "_busy_after"}, 32'(busy), 32'd0);
    end else begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_valid required=valid_within_20", nm);
    end
    @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] e_r;
    int vcount;
    logic [19:0] first_out;

    repeat (2) @(negedge clk);
    chk("reset_out", 32'(out), 32'd0);
    chk("reset_valid", 32'(valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_overrun", 32'(overrun), 32'd0);
    rst = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);

    // Boundaries and literal anchors for the model.
    directed("max_pos", 12'hFFF, 8'hFF, 1'b0, 20'h7F701, 1'b0);
    directed("max_neg", 12'h000, 8'hFF, 1'b0, 20'h80800, 1'b0);
    directed("mid_zero", 12'h800, 8'h80, 1'b0, 20'h00000, 1'b0);
    directed("small", 12'h900, 8'h01, 1'b0, 20'h00100, 1'b0);
    directed("env_zero", 12'h123, 8'h00, 1'b0, 20'h00000, 1'b0);
    directed("muted", 12'hFFF, 8'hFF, 1'b1, 20'h00000, 1'b0);
    directed("toggle_mid", 12'h000, 8'hFF, 1'b0, 20'h80800, 1'b1);

    // Random samples at a 12-CLK sample period.
    for (int i = 0; i < 2500; i++) begin
      case ($urandom_range(0, 7))
        0:       e_r = 8'h00;
        1:       e_r = 8'hFF;
        default: e_r = 8'($urandom);
      endcase
      send(12'($urandom), e_r, ($urandom_range(0, 7) == 0), 12);
    end
    // Random samples down to the minimum legal period.
    for (int i = 0; i < 500; i++)
      send(12'($urandom), 8'($urandom), 1'b0, $urandom_range(10, 13));
    repeat (12) @(negedge clk);
    chk("random_no_overrun", 32'(overrun), 32'd0);

    // Second strobe at T+4 is dropped; first result still arrives.
    @(negedge clk);
    clken = 1'b1; wave = 12'hFFF; env = 8'hFF; mute = 1'b0;
    @(negedge clk);
    clken = 1'b0;
    vcount = 0;
    first_out = '0;
    for (int k = 1; k <= 25; k++) begin
      if (valid) begin
        vcount++;
        first_out = out;
      end
      if (k == 4) begin clken = 1'b1; wave = 12'h000; end
      else clken = 1'b0;
      @(negedge clk);
    end
    chk("ovr_valid_count", 32'(vcount), 32'd1);
    chk("ovr_first_out", 32'(first_out), 32'h7F701);
    chk("ovr_flag", 32'(overrun), 32'd1);
    repeat (5) @(negedge clk);
    chk("ovr_sticky", 32'(overrun), 32'd1);

    // Asynchronous reset in the middle of a multiply.
    @(negedge clk);
    clken = 1'b1; wave = 12'h000; env = 8'hFF;
    @(negedge clk);
    clken = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_out", 32'(out), 32'd0);
    chk("rst_mid_valid", 32'(valid), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_overrun", 32'(overrun), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    vcount = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (valid) vcount++;
    end
    chk("rst_no_valid", 32'(vcount), 32'd0);

    directed("after_rst", 12'hFFF, 8'h01, 1'b0, 20'h007FF, 1'b0);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
